// File: rtl/fp32_pkg.sv
// Shared fp32 format constants, flag bundle and squarer FSM states.
// Imported by the squarer and the round/pack stage.
package fp32_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int BIAS   = 127;

  localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;
  localparam logic [31:0] FP32_PINF = 32'h7F80_0000;

  typedef struct packed {
    logic invalid;
    logic overflow;
    logic underflow;
  } fp32_flags_t;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    ROUND,
    DONE
  } sq_state_t;

endpackage

// File: rtl/fp32_round_pack.sv
// Normalize a 48-bit mantissa product, round to nearest even
// and pack an fp32 result with overflow / flush-to-zero handling.
module fp32_round_pack
  import fp32_pkg::*;
(
  input  logic [47:0]      prod,
  input  logic [EXP_W-1:0] exp_in,
  output logic [31:0]      y,
  output fp32_flags_t      flags
);

  logic              norm;
  logic              guard;
  logic              sticky;
  logic              inc;
  logic              carry;
  logic [FRAC_W-1:0] frac_raw;
  logic [FRAC_W-1:0] frac;
  logic [FRAC_W:0]   frac_sum;
  logic signed [9:0] exp_w;

  always_comb begin
    norm = prod[47];
    if (norm) begin
      frac_raw = prod[46:24];
      guard    = prod[23];
      sticky   = |prod[22:0];
    end else begin
      frac_raw = prod[45:23];
      guard    = prod[22];
      sticky   = |prod[21:0];
    end
    inc      = guard & (frac_raw[0] | sticky);
    frac_sum = {1'b0, frac_raw} + {{FRAC_W{1'b0}}, inc};
    carry    = frac_sum[FRAC_W];
    frac     = frac_sum[FRAC_W-1:0];
    // Doubled exponent of a square, one bias removed
    exp_w = {1'b0, exp_in, 1'b0} - 10'(BIAS)
          + {9'd0, norm} + {9'd0, carry};
    y     = '0;
    flags = '0;
    if (exp_w >= 10'sd255) begin
      y              = FP32_PINF;
      flags.overflow = 1'b1;
    end else if (exp_w <= 10'sd0) begin
      flags.underflow = 1'b1;
    end else begin
      y = {1'b0, exp_w[7:0], frac};
    end
  end

endmodule

// File: rtl/fp32_square_iter.sv
// Multi-cycle fp32 squarer: radix-2 shift-add mantissa product,
// RNE rounding, valid/ready handshakes on both sides.
module fp32_square_iter
  import fp32_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_y,
  output fp32_flags_t out_flags
);

  sq_state_t         state;
  logic [4:0]        cnt;
  logic [47:0]       acc;
  logic [23:0]       mcand;
  logic [23:0]       mplier;
  logic [EXP_W-1:0]  exp_q;

  logic [EXP_W-1:0]  a_exp;
  logic [FRAC_W-1:0] a_frac;
  logic              is_nan;
  logic              is_inf;
  logic              is_zero;
  logic              is_sub;
  logic              special;
  logic [31:0]       spec_y;
  fp32_flags_t       spec_flags;
  logic [31:0]       rnd_y;
  fp32_flags_t       rnd_flags;

  assign in_ready = (state == IDLE);
  assign a_exp    = in_a[30:23];
  assign a_frac   = in_a[22:0];
  assign is_nan   = (a_exp == '1) && (a_frac != '0);
  assign is_inf   = (a_exp == '1) && (a_frac == '0);
  assign is_zero  = (a_exp == '0) && (a_frac == '0);
  assign is_sub   = (a_exp == '0) && (a_frac != '0);

  // Subnormals square below 2^-252, so they flush to zero
  always_comb begin
    special    = 1'b0;
    spec_y     = '0;
    spec_flags = '0;
    unique case (1'b1)
      is_nan: begin
        special            = 1'b1;
        spec_y             = FP32_QNAN;
        spec_flags.invalid = 1'b1;
      end
      is_inf: begin
        special = 1'b1;
        spec_y  = FP32_PINF;
      end
      is_zero: special = 1'b1;
      is_sub: begin
        special              = 1'b1;
        spec_flags.underflow = 1'b1;
      end
      default: special = 1'b0;
    endcase
  end

  fp32_round_pack u_round (
    .prod   (acc),
    .exp_in (exp_q),
    .y      (rnd_y),
    .flags  (rnd_flags)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_y     <= '0;
      out_flags <= '0;
      cnt       <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      exp_q     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            exp_q  <= a_exp;
            mcand  <= {1'b1, a_frac};
            mplier <= {1'b1, a_frac};
            cnt    <= '0;
            acc    <= '0;
            if (special) begin
              out_y     <= spec_y;
              out_flags <= spec_flags;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              state <= MUL;
            end
          end
        end
        MUL: begin
          if (mplier[0])
            acc <= acc + ({24'd0, mcand} << cnt);
          mplier <= mplier >> 1;
          cnt    <= cnt + 5'd1;
          if (cnt == 5'd23)
            state <= ROUND;
        end
        ROUND: begin
          out_y     <= rnd_y;
          out_flags <= rnd_flags;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
